pc_stack: RTL and testbench



---
 rtl/pc_stack.sv | 105 ++++++++++
 tb/tb_pc_stack.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pc_stack.sv
// Clocked program counter with a return-address stack for call/ret and sticky error flag.
// Optional PC-relative branch (relPC/offset) is built when PC_REL_BRANCH_EN is defined.
module pc_stack #(
  parameter int ADDR_W      = 6,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_VEC   = 0,
  localparam int DW         = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              loadPC,
  input  logic              incPC,
  input  logic              callPC,
  input  logic              retPC,
`ifdef PC_REL_BRANCH_EN
  input  logic              relPC,
  input  logic [ADDR_W-1:0] offset,
`endif
  input  logic [ADDR_W-1:0] address,
  output logic [ADDR_W-1:0] execadd,
  output logic [DW-1:0]     stackDepth,
  output logic              stackFull,
  output logic              stackEmpty,
  output logic              errFlag
);

  localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [DW-1:0]     FULL_D = DW'(STACK_DEPTH);
  localparam logic [DW-1:0]     ONE_D  = DW'(1);
  localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);

  logic [ADDR_W-1:0] r_pc;
  logic [DW-1:0]     r_depth;
  logic              r_err;
  logic [ADDR_W-1:0] r_stack [STACK_DEPTH];

  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [DW-1:0]     w_top;
  logic              w_push;
  logic              w_pop;
  logic              w_err;
  logic              w_full;
  logic              w_empty;

  assign w_full   = (r_depth == FULL_D);
  assign w_empty  = (r_depth == '0);
  assign w_pc_inc = r_pc + ONE_A;
  assign w_top    = r_depth - ONE_D;

  // Strobe priority: ret > call > rel > load > inc. Faulting call/ret leave the PC untouched.
  always_comb begin
    w_pc_nxt = r_pc;
    w_push   = 1'b0;
    w_pop    = 1'b0;
    w_err    = 1'b0;
    if (retPC) begin
      if (w_empty) w_err = 1'b1;
      else begin
        w_pop    = 1'b1;
        w_pc_nxt = r_stack[w_top[AW-1:0]];
      end
    end else if (callPC) begin
      if (w_full) w_err = 1'b1;
      else begin
        w_push   = 1'b1;
        w_pc_nxt = address;
      end
`ifdef PC_REL_BRANCH_EN
    end else if (relPC) begin
      w_pc_nxt = r_pc + offset;
`endif
    end else if (loadPC) begin
      w_pc_nxt = address;
    end else if (incPC) begin
      w_pc_nxt = w_pc_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= ADDR_W'(RESET_VEC);
      r_depth <= '0;
      r_err   <= 1'b0;
    end else if (en) begin
      r_pc <= w_pc_nxt;
      if (w_push)     r_depth <= r_depth + ONE_D;
      else if (w_pop) r_depth <= w_top;
      if (w_err)      r_err   <= 1'b1;
    end
  end

  // Stack storage needs no reset; only entries below r_depth are ever read.
  always_ff @(posedge clk) begin
    if (en && w_push) r_stack[r_depth[AW-1:0]] <= w_pc_inc;
  end

  assign execadd    = r_pc;
  assign stackDepth = r_depth;
  assign stackFull  = w_full;
  assign stackEmpty = w_empty;
  assign errFlag    = r_err;

endmodule

// File: tb/tb_pc_stack.sv
// Bench for pc_stack: directed scenarios then random strobes, checked against a queue-based model.
module tb_pc_stack;
  localparam int AW = 6;
  localparam int SD = 4;
  localparam int DW = $clog2(SD + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0, loadPC = 1'b0, incPC = 1'b0, callPC = 1'b0, retPC = 1'b0;
  logic [AW-1:0] address = '0;
  logic [AW-1:0] execadd;
  logic [DW-1:0] stackDepth;
  logic          stackFull, stackEmpty, errFlag;
`ifdef PC_REL_BRANCH_EN
  logic          relPC = 1'b0;
  logic [AW-1:0] offset = '0;
`endif

  pc_stack #(.ADDR_W(AW), .STACK_DEPTH(SD), .RESET_VEC(0)) dut (
    .clk(clk), .rst(rst), .en(en), .loadPC(loadPC), .incPC(incPC),
    .callPC(callPC), .retPC(retPC),
`ifdef PC_REL_BRANCH_EN
    .relPC(relPC), .offset(offset),
`endif
    .address(address), .execadd(execadd), .stackDepth(stackDepth),
    .stackFull(stackFull), .stackEmpty(stackEmpty), .errFlag(errFlag)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: PC as an integer, return stack as a queue.
  int m_pc = 0;
  int m_stk[$];
  bit m_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    assert (act === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},    32'(execadd),    32'(m_pc));
    check({tag, ".depth"}, 32'(stackDepth), 32'(m_stk.size()));
    check({tag, ".full"},  32'(stackFull),  32'(m_stk.size() == SD));
    check({tag, ".empty"}, 32'(stackEmpty), 32'(m_stk.size() == 0));
    check({tag, ".err"},   32'(errFlag),    32'(m_err));
  endtask

  function automatic void model_step(bit e, bit r, bit c, bit rl, bit l, bit i, int a, int off);
    if (!e) return;
    if (r) begin
      if (m_stk.size() == 0) m_err = 1'b1;
      else m_pc = m_stk.pop_back();
    end else if (c) begin
      if (m_stk.size() == SD) m_err = 1'b1;
      else begin
        m_stk.push_back((m_pc + 1) % (1 << AW));
        m_pc = a;
      end
    end else if (rl) m_pc = (m_pc + off) % (1 << AW);
    else if (l)      m_pc = a;
    else if (i)      m_pc = (m_pc + 1) % (1 << AW);
  endfunction

  // Drive one cycle of strobes, clock it, update the model and compare.
  task automatic step(input string tag, input bit e, input bit r, input bit c, input bit rl,
                      input bit l, input bit i, input logic [AW-1:0] a, input logic [AW-1:0] off);
    en = e; retPC = r; callPC = c; loadPC = l; incPC = i; address = a;
`ifdef PC_REL_BRANCH_EN
    relPC = rl; offset = off;
`else
    if (rl || off != '0) model_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
`endif
    @(posedge clk);
    #1;
`ifdef PC_REL_BRANCH_EN
    model_step(e, r, c, rl, l, i, int'(a), int'(off));
`else
    model_step(e, r, c, 1'b0, l, i, int'(a), 0);
`endif
    check_all(tag);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset(input string tag);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    m_pc = 0; m_stk.delete(); m_err = 1'b0;
    check_all(tag);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    #12;
    m_pc = 0; m_stk.delete(); m_err = 1'b0;
    check_all("reset");
    rst = 1'b0;

    // Build execadd=0x2A with depth 2, then reset mid-cycle.
    step("t1.call0", 1, 0, 1, 0, 0, 0, 6'h10, 6'h00);
    step("t1.call1", 1, 0, 1, 0, 0, 0, 6'h2A, 6'h00);
    check("t1.pre_pc", 32'(execadd), 32'h2A);
    check("t1.pre_depth", 32'(stackDepth), 32'd2);
    async_reset("t1.async");
    check("t1.pc0", 32'(execadd), 32'h00);

    // Load, increment, wrap.
    step("t2.load", 1, 0, 0, 0, 1, 0, 6'h0A, 6'h00);
    check("t2.0A", 32'(execadd), 32'h0A);
    step("t2.inc1", 1, 0, 0, 0, 0, 1, 6'h00, 6'h00);
    step("t2.inc2", 1, 0, 0, 0, 0, 1, 6'h00, 6'h00);
    check("t2.0C", 32'(execadd), 32'h0C);
    step("t2.load3F", 1, 0, 0, 0, 1, 0, 6'h3F, 6'h00);
    step("t2.wrap", 1, 0, 0, 0, 0, 1, 6'h00, 6'h00);
    check("t2.00", 32'(execadd), 32'h00);
    step("t2.idle", 1, 0, 0, 0, 0, 0, 6'h15, 6'h00);

    // Call / inc / ret.
    step("t3.load", 1, 0, 0, 0, 1, 0, 6'h05, 6'h00);
    step("t3.call", 1, 0, 1, 0, 0, 0, 6'h20, 6'h00);
    check("t3.20", 32'(execadd), 32'h20);
    step("t3.inc", 1, 0, 0, 0, 0, 1, 6'h00, 6'h00);
    step("t3.ret", 1, 1, 0, 0, 0, 0, 6'h00, 6'h00);
    check("t3.06", 32'(execadd), 32'h06);
    check("t3.depth", 32'(stackDepth), 32'd0);

    // Overflow and underflow.
    for (int k = 0; k < 5; k++) step("t4.call", 1, 0, 1, 0, 0, 0, AW'(8 * k + 3), 6'h00);
    check("t4.full", 32'(stackFull), 32'd1);
    check("t4.err", 32'(errFlag), 32'd1);
    for (int k = 0; k < 5; k++) step("t4.ret", 1, 1, 0, 0, 0, 0, 6'h00, 6'h00);
    check("t4.empty", 32'(stackEmpty), 32'd1);
    async_reset("t4.clr");

    // Priority and stall.
    step("t5.load", 1, 0, 0, 0, 1, 0, 6'h10, 6'h00);
    step("t5.call", 1, 0, 1, 0, 0, 0, 6'h30, 6'h00);
    step("t5.prio", 1, 1, 1, 0, 1, 1, 6'h22, 6'h00);
    check("t5.11", 32'(execadd), 32'h11);
    step("t5.stall", 0, 0, 0, 0, 0, 1, 6'h00, 6'h00);
    step("t5.stallret", 0, 1, 0, 0, 0, 0, 6'h00, 6'h00);
    check("t5.noerr", 32'(errFlag), 32'd0);

`ifdef PC_REL_BRANCH_EN
    step("t6.load", 1, 0, 0, 0, 1, 0, 6'h10, 6'h00);
    step("t6.back", 1, 0, 0, 1, 0, 0, 6'h00, 6'h3E);
    check("t6.0E", 32'(execadd), 32'h0E);
    step("t6.load3F", 1, 0, 0, 0, 1, 0, 6'h3F, 6'h00);
    step("t6.fwd", 1, 0, 0, 1, 1, 1, 6'h00, 6'h02);
    check("t6.01", 32'(execadd), 32'h01);
`endif

    // Random strobes, with occasional async resets.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 60) == 0) async_reset("rnd.rst");
      else
        step("rnd", $urandom_range(0, 7) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
`ifdef PC_REL_BRANCH_EN
             $urandom_range(0, 4) == 0,
`else
             1'b0,
`endif
             $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
             AW'($urandom), AW'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
